osc_freq_counter: RTL and testbench

OSC_FREQ_COUNTER -- requirements
Module: osc_freq_counter

---
 rtl/osc_freq_counter.sv | 103 ++++++++++
 tb/tb_osc_freq_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_counter.sv
// osc_freq_counter: counts synchronised oscillator rising edges over a selectable gate of clk cycles.
// Optional FREQ_CNT_CONT_EN restarts the next measurement straight from DONE while ena is high.
module osc_freq_counter #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       osc_in,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic       byte_sel,
    output logic [7:0] count_out,
    output logic       valid,
    output logic       busy,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_q, cnt_d, result_q, result_d;
    logic             ovf_q, ovf_d, overflow_q, overflow_d, valid_q, valid_d;
    logic [13:0]      tmr_q, tmr_d, tmr_last;
    logic [1:0]       gsel_q, gsel_d;
    logic [15:0]      result_ext;
    assign edge_det   = sync_q[1] & ~sync_q[2];
    assign tmr_last   = gsel_q == 2'd0 ? 14'd255  :
                        gsel_q == 2'd1 ? 14'd1023 :
                        gsel_q == 2'd2 ? 14'd4095 : 14'd16383;
    assign result_ext = 16'(result_q);
    assign count_out  = byte_sel ? result_ext[15:8] : result_ext[7:0];
    // the held result stays flagged valid except during the ARM cycle of a new run
    assign valid      = valid_q & (state_q != ARM);
    assign busy       = state_q != IDLE;
    assign overflow   = overflow_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        tmr_d      = tmr_q;
        gsel_d     = gsel_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = start ? ARM : IDLE;
                ARM: begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = '0;
                    gsel_d  = gate_sel;
                    state_d = GATE;
                end
                GATE: begin
                    tmr_d = tmr_q + 14'd1;
                    if (edge_det) begin
                        if (&cnt_q) ovf_d = 1'b1;
                        else        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = (tmr_q == tmr_last) ? DONE : GATE;
                end
                DONE: begin
                    result_d   = cnt_q;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
`ifdef FREQ_CNT_CONT_EN
                    state_d    = ARM;
`else
                    state_d    = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            tmr_q      <= '0;
            gsel_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], osc_in};
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            tmr_q      <= tmr_d;
            gsel_q     <= gsel_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_osc_freq_counter.sv
// tb_osc_freq_counter: random and directed stimulus for a 16-bit and an 8-bit counter,
// checked each cycle against a measurement-level model.
module tb_osc_freq_counter;
    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, osc_in = 1'b0, start = 1'b0, byte_sel = 1'b0;
    logic [1:0] gate_sel = 2'd0;
    logic [7:0] co16, co8;
    logic       v16, b16, o16, v8, b8, o8;
    int osc_per = 8, osc_lvl = 0, ph = 0;
    int n_cmp = 0, n_bad = 0;
    int pos = -1, gn = 0, edges = 0, res = 0, vld = 0;
    bit a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
`ifdef FREQ_CNT_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    always #5 clk = ~clk;

    osc_freq_counter #(.CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start), .gate_sel(gate_sel),
        .byte_sel(byte_sel), .count_out(co16), .valid(v16), .busy(b16), .overflow(o16));
    osc_freq_counter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start), .gate_sel(gate_sel),
        .byte_sel(byte_sel), .count_out(co8), .valid(v8), .busy(b8), .overflow(o8));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_byte(input int w, input bit bs);
        int m = (1 << w) - 1;
        int v = (res > m) ? m : res;
        return bs ? (v >> 8) & 255 : v & 255;
    endfunction

    // oscillator: 0 = static level, 1 = random bits, >=2 = square wave of that period in clk cycles
    initial forever begin
        @(negedge clk);
        ph++;
        osc_in = (osc_per == 0) ? 1'(osc_lvl) : (osc_per == 1) ? 1'($urandom) : ((ph % osc_per) < (osc_per / 2));
    end

    // model: pos -1 idle, 0 arm, 1..gn gate cycles, gn+1 done; edges seen two clocks late
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            pos = -1; edges = 0; res = 0; vld = 0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        end else begin
            if (!ena) begin
                pos = -1;
            end else if (pos < 0) begin
                if (start) pos = 0;
            end else if (pos == 0) begin
                edges = 0;
                gn = 256 << (2 * int'(gate_sel));
                pos = 1;
            end else if (pos <= gn) begin
                if (a2 && !a3) edges++;
                pos = (pos == gn) ? gn + 1 : pos + 1;
            end else begin
                res = edges;
                vld = 1;
                pos = CONT ? 0 : -1;
            end
            a3 = a2; a2 = a1; a1 = osc_in;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        chk("busy16", int'(b16), int'(pos >= 0));
        chk("busy8", int'(b8), int'(pos >= 0));
        chk("valid16", int'(v16), int'(vld != 0 && pos != 0));
        chk("valid8", int'(v8), int'(vld != 0 && pos != 0));
        chk("ovf16", int'(o16), int'(res > 65535));
        chk("ovf8", int'(o8), int'(res > 255));
        chk("count16", int'(co16), exp_byte(16, byte_sel));
        chk("count8", int'(co8), exp_byte(8, byte_sel));
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic measure(input string name, input int exp_len, input bit rep);
        int len = 0;
        while (b16 && len < 20000) begin
            @(negedge clk);
            len++;
            start = rep && (len % 97 == 5);
            if (len >= 2) gate_sel = 2'($urandom);
        end
        start = 1'b0;
        chk(name, len, exp_len);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_co16"}, int'(co16), 0); chk({name, "_v16"}, int'(v16), 0);
        chk({name, "_b16"}, int'(b16), 0);   chk({name, "_o16"}, int'(o16), 0);
        chk({name, "_co8"}, int'(co8), 0);   chk({name, "_v8"}, int'(v8), 0);
        chk({name, "_b8"}, int'(b8), 0);     chk({name, "_o8"}, int'(o8), 0);
    endtask

    initial begin
        cyc(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        ena = 1'b1;
        cyc(4);
`ifdef FREQ_CNT_CONT_EN
        osc_per = 16;
        pulse_start();
        cyc(300);
        begin
            int t = 0;
            while (v16 && t < 400) begin @(negedge clk); t++; end
            for (int r = 0; r < 3; r++) begin
                t = 0;
                while (!v16 && t < 400) begin @(negedge clk); t++; end
                while (v16 && t < 400) begin @(negedge clk); t++; end
                chk("cont_period", t, 258);
                chk("cont_count", int'(co16), 16);
            end
        end
`else
        pulse_start();
        measure("len_g0", 258, 1'b0);
        chk("g0_co16", int'(co16), 32); chk("g0_co8", int'(co8), 32);
        chk("g0_v16", int'(v16), 1);    chk("g0_o16", int'(o16), 0);
        byte_sel = 1'b1; #1;
        chk("g0_hi16", int'(co16), 0);  chk("g0_hi8", int'(co8), 0);
        byte_sel = 1'b0;
        osc_per = 2; gate_sel = 2'd1;
        cyc(4);
        pulse_start();
        measure("len_g1", 1026, 1'b0);
        chk("sat_co16", int'(co16), 0); chk("sat_co8", int'(co8), 255);
        chk("sat_o8", int'(o8), 1);     chk("sat_o16", int'(o16), 0);
        byte_sel = 1'b1; #1;
        chk("sat_hi16", int'(co16), 2);
        byte_sel = 1'b0;
        osc_per = 0; osc_lvl = 1; gate_sel = 2'd3;
        cyc(6);
        pulse_start();
        measure("len_g3", 16386, 1'b1);
        chk("hi_co16", int'(co16), 0);  chk("hi_co8", int'(co8), 0);
        chk("hi_v16", int'(v16), 1);    chk("hi_o8", int'(o8), 0);
        osc_per = 8; gate_sel = 2'd0;
        cyc(2);
        pulse_start();
        measure("len_run1", 258, 1'b1);
        chk("run1_co16", int'(co16), 32);
        osc_per = 10; gate_sel = 2'd0;
        pulse_start();
        cyc(101);
        ena = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(b16), 0); chk("abort_valid", int'(v16), 1);
        chk("abort_co16", int'(co16), 32);
        ena = 1'b1;
        cyc(2);
        pulse_start();
        cyc(50);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        cyc(2);
        rst_n = 1'b1;
`endif
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if (i % 1000 == 0) begin
                osc_per = $urandom_range(0, 20);
                osc_lvl = $urandom_range(0, 1);
            end
            start = ($urandom_range(0, 63) == 0);
            ena = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 7) == 0) gate_sel = 2'($urandom_range(0, 2));
            byte_sel = 1'($urandom);
            if (i == 7777) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
